// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load-use hazard: the load in ID/EX targets a register the ID instruction reads.
module load_use_detect #(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_valid,
  input  logic             id_rt_valid,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [REG_W-1:0] idex_write_r,
  output logic             hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_valid && (id_rs == idex_write_r);
  assign rt_hit = id_rt_valid && (id_rt == idex_write_r);
  assign hazard = idex_mem_read && idex_reg_write && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: combinational stage controls from registered state plus
// current hazard inputs, a HALT drain counter and a saturating stall counter.
// Handshake note: no valid/ready here; every control is a level valid in the current cycle.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int REG_W        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_rs_valid,
  input  logic                   id_rt_valid,
  input  logic                   idex_mem_read,
  input  logic                   idex_reg_write,
  input  logic [REG_W-1:0]       idex_write_r,
  input  logic                   exmem_mem_read,
  input  logic                   exmem_mem_write,
  input  logic                   mem_stall,
  input  logic                   ex_redirect,
  input  logic                   exmem_halt,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   exmem_bubble,
  output logic                   memwb_bubble,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output state_t                 fsm_state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] drain_cnt;
  logic          mem_busy;
  logic          load_use;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_valid    (id_rs_valid),
    .id_rt_valid    (id_rt_valid),
    .idex_mem_read  (idex_mem_read),
    .idex_reg_write (idex_reg_write),
    .idex_write_r   (idex_write_r),
    .hazard         (load_use)
  );

  assign mem_busy  = (exmem_mem_read || exmem_mem_write) && mem_stall;
  assign fsm_state = state;

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    state_nxt    = state;
    if (!rst) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
      state_nxt    = RUN;
    end else begin
      case (state)
        // MEM_WAIT shares RUN's rules so a cleared stall resolves in the same cycle.
        RUN, MEM_WAIT: begin
          state_nxt = RUN;
          if (mem_busy) begin
            memwb_en     = 1'b1;
            memwb_bubble = 1'b1;
            state_nxt    = MEM_WAIT;
          end else if (exmem_halt) begin
            exmem_en     = 1'b1;
            exmem_bubble = 1'b1;
            memwb_en     = 1'b1;
            state_nxt    = DRAIN;
          end else if (ex_redirect) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        DRAIN: begin
          exmem_en     = 1'b1;
          exmem_bubble = 1'b1;
          memwb_en     = 1'b1;
          if (drain_cnt == '0) state_nxt = HALTED;
        end
        default: begin
          halted    = 1'b1;
          state_nxt = HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      drain_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if ((state == RUN || state == MEM_WAIT) && state_nxt == DRAIN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
      if (state != HALTED && !pc_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a behavioural model
// of stage controls, HALT drain timing and the saturating stall counter.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int DC = 2;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs, id_rt, idex_write_r;
  logic          id_rs_valid, id_rt_valid, idex_mem_read, idex_reg_write;
  logic          exmem_mem_read, exmem_mem_write, mem_stall, ex_redirect, exmem_halt;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, halted;
  logic [15:0]   stall_cycles;
  state_t        fsm_state;

  int total = 0;
  int bad   = 0;

  // Behavioural model: halted flag, drain cycles still to show, stall count.
  bit m_halted;
  int m_drain_left;
  int m_cnt;

  pipeline_ctrl #(.DRAIN_CYCLES(DC), .REG_W(RW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_write_r(idex_write_r),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write), .mem_stall(mem_stall),
    .ex_redirect(ex_redirect), .exmem_halt(exmem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .memwb_bubble(memwb_bubble), .halted(halted), .stall_cycles(stall_cycles), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Bit order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, halted
  function automatic logic [9:0] exp_ctrl();
    bit access, lu;
    access = (exmem_mem_read | exmem_mem_write) & mem_stall;
    lu = idex_mem_read & idex_reg_write &
         ((id_rs_valid & (id_rs == idex_write_r)) | (id_rt_valid & (id_rt == idex_write_r)));
    if (!rst)               return 10'b00000_1111_0;
    if (m_halted)           return 10'b00000_0000_1;
    if (m_drain_left > 0)   return 10'b00011_0010_0;
    if (access)             return 10'b00001_0001_0;
    if (exmem_halt)         return 10'b00011_0010_0;
    if (ex_redirect)        return 10'b11111_1100_0;
    if (lu)                 return 10'b00111_0100_0;
    return 10'b11111_0000_0;
  endfunction

  task automatic model_update();
    logic [9:0] e;
    bit access;
    e = exp_ctrl();
    access = (exmem_mem_read | exmem_mem_write) & mem_stall;
    if (!rst) begin
      m_halted = 0; m_drain_left = 0; m_cnt = 0;
    end else if (!m_halted) begin
      if (!e[9] && m_cnt < 65535) m_cnt++;
      if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end else if (!access && exmem_halt) begin
        m_drain_left = DC;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [9:0] obs, e;
    int exp_cnt;
    obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, halted};
    e = exp_ctrl();
    exp_cnt = rst ? m_cnt : 0;
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s_ctrl observed=%b expected=%b", tag, obs, e);
    end
    total++;
    assert (stall_cycles === 16'(exp_cnt)) else begin
      bad++;
      $error("FAIL %s_stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_cnt);
    end
  endtask

  // Inputs are set shortly after a rising edge; checks run before the falling edge.
  task automatic tick(input string tag);
    #2;
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_rs_valid = 0; id_rt_valid = 0;
    idex_mem_read = 0; idex_reg_write = 0; idex_write_r = '0;
    exmem_mem_read = 0; exmem_mem_write = 0; mem_stall = 0;
    ex_redirect = 0; exmem_halt = 0;
  endtask

  initial begin
    rst = 1'b0;
    m_halted = 0; m_drain_left = 0; m_cnt = 0;
    clear_inputs();
    @(posedge clk); #1;
    tick("reset");
    tick("reset");
    rst = 1'b1;
    tick("idle");

    // Load-use: one stall cycle, then the bubble removes the load from ID/EX.
    idex_mem_read = 1; idex_reg_write = 1; idex_write_r = 3; id_rs = 3; id_rs_valid = 1;
    tick("load_use");
    idex_mem_read = 0;
    tick("load_use_after");
    total++;
    assert (stall_cycles === 16'd1) else begin
      bad++;
      $error("FAIL load_use_count observed=%0d expected=1", stall_cycles);
    end
    clear_inputs();

    // Data-memory stall for three cycles.
    exmem_mem_read = 1; mem_stall = 1;
    repeat (3) tick("mem_wait");
    mem_stall = 0;
    tick("mem_release");
    total++;
    assert (stall_cycles === 16'd4) else begin
      bad++;
      $error("FAIL mem_stall_count observed=%0d expected=4", stall_cycles);
    end
    clear_inputs();

    // Redirect beats load-use.
    ex_redirect = 1; idex_mem_read = 1; idex_reg_write = 1; idex_write_r = 5;
    id_rt = 5; id_rt_valid = 1;
    tick("redirect_lu");
    clear_inputs();

    // mem_stall without an access has no effect; then stall over redirect + halt.
    mem_stall = 1;
    tick("stall_no_access");
    exmem_mem_write = 1; ex_redirect = 1; exmem_halt = 1;
    tick("busy_beats_halt");
    mem_stall = 0; exmem_halt = 0;
    tick("redirect_after_stall");
    clear_inputs();

    // Randomized traffic, HALT excluded.
    for (int i = 0; i < 400; i++) begin
      id_rs = RW'($urandom_range(0, 7)); id_rt = RW'($urandom_range(0, 7));
      id_rs_valid = 1'($urandom_range(0, 1)); id_rt_valid = 1'($urandom_range(0, 1));
      idex_mem_read = 1'($urandom_range(0, 1)); idex_reg_write = 1'($urandom_range(0, 1));
      idex_write_r = RW'($urandom_range(0, 7));
      exmem_mem_read = 1'($urandom_range(0, 1)); exmem_mem_write = 1'($urandom_range(0, 3) == 0);
      mem_stall = 1'($urandom_range(0, 2) == 0);
      ex_redirect = 1'($urandom_range(0, 3) == 0);
      tick("random");
    end
    clear_inputs();

    // Saturation of the stall counter.
    exmem_mem_read = 1; mem_stall = 1;
    repeat (65540) tick("saturate");
    total++;
    assert (stall_cycles === 16'hFFFF) else begin
      bad++;
      $error("FAIL saturate_hold observed=%0h expected=ffff", stall_cycles);
    end
    clear_inputs();

    // HALT drain, then halted holds even with a redirect asserted.
    exmem_halt = 1;
    repeat (DC + 1) tick("halt_drain");
    exmem_halt = 0; ex_redirect = 1;
    repeat (10) tick("halted_hold");
    total++;
    assert (halted === 1'b1) else begin
      bad++;
      $error("FAIL halted_flag observed=%b expected=1", halted);
    end
    clear_inputs();

    // Reset mid-DRAIN, then resume in RUN.
    rst = 0;
    tick("reset_halted");
    rst = 1;
    tick("run_after_reset");
    exmem_halt = 1;
    tick("halt_again");
    exmem_halt = 0;
    tick("drain_again");
    rst = 0;
    tick("reset_mid_drain");
    rst = 1;
    tick("post_reset_run");
    ex_redirect = 1;
    tick("post_reset_redirect");
    clear_inputs();
    tick("post_reset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
